// File: rtl/vc_fifo_if.sv
// Link bundle between the upstream router, the multi-VC input buffer and the input controller.
// master = traffic source/sink side (router link + input controller), slave = the buffer.
interface vc_fifo_if #(
  parameter int packetwidth  = 55,
  parameter int addressWidth = 3,
  parameter int numVC        = 4,
  parameter int vcWidth      = 2
);
  logic                              reqUpStr;
  logic [vcWidth-1:0]                vcIn;
  logic [packetwidth-1:0]            PacketIn;
  logic                              gntUpStr;
  logic                              reqInCtr;
  logic [vcWidth-1:0]                vcOut;
  logic                              gntInCtr;
  logic [packetwidth-1:0]            PacketOut;
  logic [numVC-1:0]                  full;
  logic [numVC-1:0]                  empty;
  logic [numVC*(addressWidth+1)-1:0] count;

  modport master (
    output reqUpStr, vcIn, PacketIn, reqInCtr, vcOut,
    input  gntUpStr, gntInCtr, PacketOut, full, empty, count
  );

  modport slave (
    input  reqUpStr, vcIn, PacketIn, reqInCtr, vcOut,
    output gntUpStr, gntInCtr, PacketOut, full, empty, count
  );
endinterface

// File: rtl/vc_fifo.sv
// Multi-VC input buffer: numVC circular queues share one packet RAM; grants and PacketOut arrive one cycle after the request.
// Backpressure: a full or out-of-range VC is simply not granted; upstream must drop reqUpStr between packets.
module vc_fifo #(
  parameter int packetwidth  = 55,
  parameter int addressWidth = 3,
  parameter int numVC        = 4,
  parameter int vcWidth      = 2
) (
  input logic      clk,
  input logic      reset,
  vc_fifo_if.slave bus
);
  localparam int DEPTH = 1 << addressWidth;
  localparam int CW    = addressWidth + 1;
  localparam int AW    = $clog2(numVC * DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [packetwidth-1:0]  mem    [numVC*DEPTH];
  logic [addressWidth-1:0] wr_ptr [numVC];
  logic [addressWidth-1:0] rd_ptr [numVC];
  logic [CW-1:0]           cnt    [numVC];

  logic                    enable_gnt;
  logic                    gnt_up;
  logic                    gnt_in;
  logic [packetwidth-1:0]  pkt_out;

  logic                    sel_full;
  logic                    sel_empty;
  logic [addressWidth-1:0] sel_wr_ptr;
  logic [addressWidth-1:0] sel_rd_ptr;
  logic                    wr_ok;
  logic                    rd_ok;
  logic [AW-1:0]           wr_addr;
  logic [AW-1:0]           rd_addr;
  logic [numVC-1:0]        wr_hit;
  logic [numVC-1:0]        rd_hit;
  logic [numVC-1:0]        full_v;
  logic [numVC-1:0]        empty_v;

  for (genvar i = 0; i < numVC; i++) begin : g_flags
    assign full_v[i]  = (cnt[i] == FULL_CNT);
    assign empty_v[i] = (cnt[i] == '0);
    assign wr_hit[i]  = wr_ok && (bus.vcIn == vcWidth'(i));
    assign rd_hit[i]  = rd_ok && (bus.vcOut == vcWidth'(i));
  end

  // Defaults of full/empty = 1 make an index >= numVC match nothing, so it is never granted.
  always_comb begin
    sel_full   = 1'b1;
    sel_empty  = 1'b1;
    sel_wr_ptr = '0;
    sel_rd_ptr = '0;
    for (int i = 0; i < numVC; i++) begin
      if (bus.vcIn == vcWidth'(i)) begin
        sel_full   = full_v[i];
        sel_wr_ptr = wr_ptr[i];
      end
      if (bus.vcOut == vcWidth'(i)) begin
        sel_empty  = empty_v[i];
        sel_rd_ptr = rd_ptr[i];
      end
    end
  end

  assign wr_ok   = bus.reqUpStr && enable_gnt && !sel_full;
  assign rd_ok   = bus.reqInCtr && !sel_empty;
  assign wr_addr = AW'({bus.vcIn, sel_wr_ptr});
  assign rd_addr = AW'({bus.vcOut, sel_rd_ptr});

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= bus.PacketIn;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_up     <= 1'b0;
      gnt_in     <= 1'b0;
      pkt_out    <= '0;
      enable_gnt <= 1'b1;
      for (int i = 0; i < numVC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      gnt_up <= wr_ok;
      gnt_in <= rd_ok;
      if (rd_ok) pkt_out <= mem[rd_addr];
      // One grant per request assertion: re-armed only by a cycle with the request low.
      if (!bus.reqUpStr) enable_gnt <= 1'b1;
      else if (wr_ok)    enable_gnt <= 1'b0;
      for (int i = 0; i < numVC; i++) begin
        if (wr_hit[i]) wr_ptr[i] <= wr_ptr[i] + addressWidth'(1);
        if (rd_hit[i]) rd_ptr[i] <= rd_ptr[i] + addressWidth'(1);
        if (wr_hit[i] && !rd_hit[i])      cnt[i] <= cnt[i] + CW'(1);
        else if (!wr_hit[i] && rd_hit[i]) cnt[i] <= cnt[i] - CW'(1);
      end
    end
  end

  always_comb begin
    bus.count = '0;
    for (int i = 0; i < numVC; i++) bus.count[i*CW +: CW] = cnt[i];
  end

  assign bus.gntUpStr  = gnt_up;
  assign bus.gntInCtr  = gnt_in;
  assign bus.PacketOut = pkt_out;
  assign bus.full      = full_v;
  assign bus.empty     = empty_v;
endmodule
